dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, data-memory byte-address width.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pN_req_valid  in  1  request from port N (N=0 core, N=1 debug).
REQ-005 pN_req_ready  out  1  request accepted this cycle.
REQ-006 pN_req_we  in  1  1=store, 0=load.
REQ-007 pN_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 pN_req_unsigned  in  1  zero-extend load (1) or sign-extend (0).
REQ-009 pN_req_addr  in  ADDR_W  byte address.
REQ-010 pN_req_wdata  in  32  store data, right-justified.
REQ-011 pN_rsp_valid  out  1  one-cycle completion pulse.
REQ-012 pN_rsp_rdata  out  32  formatted load data; 0 for stores.
REQ-013 pN_rsp_err  out  1  access error, valid with rsp_valid.
REQ-014 mem_addr  out  ADDR_W  word-aligned memory address.
REQ-015 mem_wdata  out  32  memory write word.
REQ-016 mem_op / mem_wr  out  1 each  memory enable / write strobe.
REQ-017 mem_rdata  in  32  memory read word, registered, valid the cycle after mem_op=1 with mem_wr=0.

Function
REQ-018 FSM states: IDLE, RD, RDW, WR, RESP; one transaction in flight.
REQ-019 IDLE: if any valid, grant one port, assert its req_ready for that cycle only, and latch the request; the next state is RD for a load or sub-word store and WR for a word store.
REQ-020 Arbitration is round-robin: on simultaneous valid, the port not granted last wins; a lone valid wins immediately; pointer favours p0 after reset.
REQ-021 req_ready stays 0 in every state except IDLE; requesters hold the request until ready.
REQ-022 RD drives mem_op=1, mem_wr=0, mem_addr={addr[ADDR_W-1:2],2'b00}, then goes to RDW.
REQ-023 RDW: on a load, format mem_rdata and go to RESP; on a sub-word store, merge wdata into the addressed lane(s) of mem_rdata and go to WR.
REQ-024 WR drives mem_op=1, mem_wr=1, aligned mem_addr, merged/word data, then goes to RESP.
REQ-025 RESP pulses the owner's rsp_valid for one cycle, then returns to IDLE; the response has no backpressure.
REQ-026 Load format: byte lane addr[1:0], half lane addr[1]; extend to 32 bits per unsigned.
REQ-027 Latency, accept cycle = 0: word store rsp at cycle 2, load at 3, sub-word store at 4.
REQ-028 Outside RD/WR, mem_op=0 and mem_wr=0; mem_wdata=0 when mem_wr=0.

Reset
REQ-029 When rst=1, the next state is IDLE, the RR pointer is p0, and all outputs are 0.
REQ-030 Reset mid-transaction discards it: no rsp_valid is issued, and no memory write occurs after the reset edge.

Configuration
REQ-031 Macro DMEM_ARB_MISALIGN_CHK_EN defined: a half access with addr[0]=1, a word access with addr[1:0]≠0, or size=11 goes IDLE→RESP with no memory access, rsp_err=1 and rdata=0.
REQ-032 Macro undefined: the low address bits beyond the access size are ignored, size=11 is treated as a word access, and rsp_err is constant 0.

Structure
REQ-033 Package dmem_pkg holds the size encodings, the FSM state enum and the ADDR_W default.
REQ-034 Sub-module rr_arb2 (2-input round-robin, grant plus pointer update on accept) is instantiated once.

Verification
REQ-035 p0 word store 0xDEADBEEF @0x010 → mem_wr=1 at cycle 1 with data 0xDEADBEEF; p0 rsp_valid at cycle 2, err=0.
REQ-036 Memory word @0x020=0x80FF7F01, p1 signed byte load @0x022 → rsp_rdata=0xFFFFFFFF at cycle 3; unsigned half load @0x022 → 0x000080FF.
REQ-037 Memory @0x030=0x11223344, p0 byte store 0xAA @0x031 → one RD then one WR of 0x1122AA44; rsp at cycle 4.
REQ-038 p0 and p1 both valid and held for 4 transactions → grants alternate p0,p1,p0,p1; each rsp goes only to its owner.
REQ-039 Assert rst during RDW of a sub-word store → no WR, no rsp_valid, IDLE next cycle, memory unchanged.
REQ-040 With DMEM_ARB_MISALIGN_CHK_EN, word load @0x013 → no mem_op, rsp_err=1 at cycle 1; without the macro → read of @0x010, err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: size codes, FSM states, address width default and lane helpers for dmem_arbiter
package dmem_pkg;
  localparam int ADDR_W_DEF = 12;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WR,
    S_RESP
  } state_e;
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input size_e sz, input logic uns,
                                           input logic [1:0] a);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    return sz == SZ_BYTE ? {{24{b[7] & ~uns}}, b} : sz == SZ_HALF ? {{16{h[15] & ~uns}}, h} : w;
  endfunction
  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] d,
                                              input size_e sz, input logic [1:0] a);
    logic [31:0] m;
    m = w;
    if (sz == SZ_BYTE) m[{a, 3'b000} +: 8] = d[7:0];
    else if (sz == SZ_HALF) m[{a[1], 4'b0000} +: 16] = d[15:0];
    else m = d;
    return m;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_RSVD || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port (request handshake plus completion pulse) of dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_pkg::ADDR_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  modport master(
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave(
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin grant; priority passes to the other port on every accepted grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  assign gnt[1] = req[1] && (!req[0] || ptr_q);
  assign gnt[0] = req[0] && !gnt[1];
  assign ptr_d  = accept ? gnt[0] : ptr_q;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: 2-port round-robin data-memory arbiter with lane formatting; DMEM_ARB_MISALIGN_CHK_EN enables misalignment errors
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_op,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata
);
  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic              owner_q, owner_d, we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        gnt;
  logic              accept, sel, g_we, g_uns, rsp;
  logic [1:0]        g_size;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_wdata;

  assign accept = !rst && state_q == S_IDLE && (p0.req_valid || p1.req_valid);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({p1.req_valid, p0.req_valid}),
    .accept(accept),
    .gnt   (gnt)
  );

  assign sel     = gnt[1];
  assign g_we    = sel ? p1.req_we : p0.req_we;
  assign g_size  = sel ? p1.req_size : p0.req_size;
  assign g_uns   = sel ? p1.req_unsigned : p0.req_unsigned;
  assign g_addr  = sel ? p1.req_addr : p0.req_addr;
  assign g_wdata = sel ? p1.req_wdata : p0.req_wdata;

  // data_q carries store data until RDW, then the merged word or the formatted load result
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (accept) begin
        owner_d = sel;
        we_d    = g_we;
        size_d  = g_size == SZ_RSVD ? SZ_WORD : size_e'(g_size);
        uns_d   = g_uns;
        addr_d  = g_addr;
        data_d  = g_wdata;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        err_d   = misaligned(g_size, g_addr[1:0]);
`else
        err_d   = 1'b0;
`endif
        state_d = err_d ? S_RESP : (g_we && size_d == SZ_WORD) ? S_WR : S_RD;
      end
      S_RD: state_d = S_RDW;
      S_RDW: begin
        data_d  = we_q ? merge_store(mem_rdata, data_q, size_q, addr_q[1:0])
                       : fmt_load(mem_rdata, size_q, uns_q, addr_q[1:0]);
        state_d = we_q ? S_WR : S_RESP;
      end
      S_WR: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // every output is gated by rst so a mid-transaction reset is silent in its own cycle
  assign rsp          = !rst && state_q == S_RESP;
  assign mem_op       = !rst && (state_q == S_RD || state_q == S_WR);
  assign mem_wr       = !rst && state_q == S_WR;
  assign mem_addr     = mem_op ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata    = mem_wr ? data_q : '0;
  assign p0.req_ready = accept && gnt[0];
  assign p1.req_ready = accept && gnt[1];
  assign p0.rsp_valid = rsp && !owner_q;
  assign p1.rsp_valid = rsp && owner_q;
  assign p0.rsp_err   = p0.rsp_valid && err_q;
  assign p1.rsp_err   = p1.rsp_valid && err_q;
  assign p0.rsp_rdata = (p0.rsp_valid && !we_q && !err_q) ? data_q : '0;
  assign p1.rsp_rdata = (p1.rsp_valid && !we_q && !err_q) ? data_q : '0;
endmodule
